// File: rtl/viterbi_ctrl_seq.sv
// viterbi_ctrl_seq: frame sequencer (start/frame_len/sym_valid in; stage enables, mem_addr/tb_addr, busy/done/err out)
module viterbi_ctrl_seq #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] frame_len,
  input  logic             sym_valid,
  output logic             en_ext,
  output logic             en_brch,
  output logic             en_acs,
  output logic             en_mem,
  output logic             en_trbk,
  output logic [CNT_W-1:0] mem_addr,
  output logic [CNT_W-1:0] tb_addr,
  output logic             busy,
  output logic             done,
  output logic             err
);
  typedef enum logic [1:0] {IDLE, RUN, TRBK, DONE} state_t;
  state_t state, state_n;
  logic [CNT_W-1:0] n, sym_cnt;
  logic v1, v2, accept, last_wr;
  always_comb begin
    accept = state == IDLE && start && frame_len > CNT_W'(1);
    en_ext = state == RUN && sym_valid && sym_cnt < n;
    en_brch = state == RUN && v1;
    en_acs = en_brch;
    en_trbk = state == TRBK;
    en_mem = (state == RUN && v2) || en_trbk;
    busy = state != IDLE;
    done = state == DONE;
    last_wr = state == RUN && v2 && mem_addr == n - CNT_W'(1);
    state_n = state == IDLE ? (accept ? RUN : IDLE) :
              state == RUN  ? (last_wr ? TRBK : RUN) :
              state == TRBK ? (tb_addr == '0 ? DONE : TRBK) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      n <= '0;
      sym_cnt <= '0;
      mem_addr <= '0;
      tb_addr <= '0;
      v1 <= 1'b0;
      v2 <= 1'b0;
      err <= 1'b0;
    end else begin
      err <= state == IDLE && start && frame_len < CNT_W'(2);
      if (accept) begin
        n <= frame_len;
        sym_cnt <= '0;
        mem_addr <= '0;
        v1 <= 1'b0;
        v2 <= 1'b0;
      end
      if (state == RUN) begin
        v1 <= en_ext;
        v2 <= v1;
        sym_cnt <= sym_cnt + CNT_W'(en_ext);
        if (v2 && !last_wr) mem_addr <= mem_addr + CNT_W'(1);
        if (last_wr) tb_addr <= n - CNT_W'(1);
      end
      if (state == TRBK && tb_addr != '0) tb_addr <= tb_addr - CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_viterbi_ctrl_seq.sv
// tb_viterbi_ctrl_seq: randomized self-checking bench against a behavioural frame model
module tb_viterbi_ctrl_seq;
  localparam int W = 8;
  localparam int M_IDLE = 0, M_RUN = 1, M_TRBK = 2, M_DONE = 3;
  logic clk = 1'b0, rst = 1'b1, start = 1'b1, sym_valid = 1'b1;
  logic [W-1:0] frame_len = '0;
  logic en_ext, en_brch, en_acs, en_mem, en_trbk, busy, done, err;
  logic [W-1:0] mem_addr, tb_addr;
  logic start4 = 1'b0, sv4 = 1'b0;
  logic [3:0] fl4 = '0;
  logic en_ext4, en_brch4, en_acs4, en_mem4, en_trbk4, busy4, done4, err4;
  logic [3:0] mem_addr4, tb_addr4;
  int n_chk = 0, n_fail = 0, cyc = 0;
  int ph = M_IDLE, mn = 0, consumed = 0, written = 0, traced = 0;
  bit ext_1ago = 0, ext_2ago = 0, err_q = 0, fresh = 0, armed = 0;
  int ext_cnt = 0, wr_cnt = 0, last_wr_addr = -1, trbk_cnt = 0, done_cnt = 0, err_cnt = 0;
  int first_ext_cyc = 0, done_cyc = 0, prev_done_cyc = 0;
  bit ext_seen = 0;

  viterbi_ctrl_seq #(.CNT_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .frame_len(frame_len), .sym_valid(sym_valid),
    .en_ext(en_ext), .en_brch(en_brch), .en_acs(en_acs), .en_mem(en_mem), .en_trbk(en_trbk),
    .mem_addr(mem_addr), .tb_addr(tb_addr), .busy(busy), .done(done), .err(err)
  );

  viterbi_ctrl_seq #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .frame_len(fl4), .sym_valid(sv4),
    .en_ext(en_ext4), .en_brch(en_brch4), .en_acs(en_acs4), .en_mem(en_mem4), .en_trbk(en_trbk4),
    .mem_addr(mem_addr4), .tb_addr(tb_addr4), .busy(busy4), .done(done4), .err(err4)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit e_ext, e_brch, e_mem;
    cyc++;
    e_ext = 0;
    e_mem = 0;
    if (armed) begin
      e_ext = ph == M_RUN && sym_valid && consumed < mn;
      e_brch = ph == M_RUN && ext_1ago;
      e_mem = (ph == M_RUN && ext_2ago) || ph == M_TRBK;
      chk("en_ext", en_ext, e_ext);
      chk("en_brch", en_brch, e_brch);
      chk("en_acs", en_acs, e_brch);
      chk("en_mem", en_mem, e_mem);
      chk("en_trbk", en_trbk, ph == M_TRBK);
      chk("busy", busy, ph != M_IDLE);
      chk("done", done, ph == M_DONE);
      chk("err", err, err_q);
      if (ph == M_RUN && e_mem) chk("mem_addr", mem_addr, written);
      if (ph == M_TRBK) chk("tb_addr", tb_addr, mn - 1 - traced);
      if (ph == M_IDLE && fresh) begin
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_tb_addr", tb_addr, 0);
      end
      if (en_ext) begin
        ext_cnt++;
        if (!ext_seen) begin first_ext_cyc = cyc; ext_seen = 1; end
      end
      if (en_mem && !en_trbk) begin wr_cnt++; last_wr_addr = int'(mem_addr); end
      if (en_trbk) trbk_cnt++;
      if (done) begin done_cnt++; prev_done_cyc = done_cyc; done_cyc = cyc; ext_seen = 0; end
      if (err) err_cnt++;
    end
    if (rst) begin
      ph = M_IDLE; ext_1ago = 0; ext_2ago = 0; err_q = 0; fresh = 1; armed = 1; ext_seen = 0;
    end else if (armed) begin
      err_q = 0;
      case (ph)
        M_IDLE: begin
          if (start && frame_len >= 2) begin
            ph = M_RUN; mn = int'(frame_len); consumed = 0; written = 0;
            ext_1ago = 0; ext_2ago = 0; fresh = 0;
          end else err_q = start;
        end
        M_RUN: begin
          if (e_mem) begin
            if (written == mn - 1) begin ph = M_TRBK; traced = 0; end
            else written++;
          end
          ext_2ago = ext_1ago;
          ext_1ago = e_ext;
          consumed += int'(e_ext);
        end
        M_TRBK: begin
          traced++;
          if (traced == mn) ph = M_DONE;
        end
        default: ph = M_IDLE;
      endcase
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_to_idle(input int pct, input bit spam);
    int k = 0;
    while (ph != M_IDLE && k < 2000) begin
      sym_valid = $urandom_range(99) < pct;
      start = spam && $urandom_range(1) == 1;
      frame_len = W'($urandom);
      tick;
      k++;
    end
    start = 0;
    if (ph != M_IDLE) begin
      n_chk++; n_fail++;
      $display("FAIL frame_timeout: phase %0d, required idle", ph);
    end
  endtask

  task automatic frame(input int fl, input int pct, input bit spam);
    start = 1;
    frame_len = W'(fl);
    tick;
    run_to_idle(pct, spam);
  endtask

  initial begin
    int e0, w0, t0, d0, r0, k, w4, t4, d4, x4, b4;
    bit pat[8];
    pat = '{1, 0, 1, 1, 0, 0, 1, 1};
    repeat (3) @(posedge clk);
    #1;
    rst = 0; start = 0; sym_valid = 0;
    tick;
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_ext_cnt", ext_cnt, 0);

    e0 = ext_cnt; w0 = wr_cnt; t0 = trbk_cnt; d0 = done_cnt;
    frame(4, 100, 0);
    chk("n4_ext", ext_cnt - e0, 4);
    chk("n4_wr", wr_cnt - w0, 4);
    chk("n4_last_wr", last_wr_addr, 3);
    chk("n4_trbk", trbk_cnt - t0, 4);
    chk("n4_done", done_cnt - d0, 1);
    chk("n4_latency", done_cyc - first_ext_cyc, 10);

    e0 = ext_cnt; w0 = wr_cnt; t0 = trbk_cnt; d0 = done_cnt;
    start = 1; frame_len = 5; tick; start = 0;
    for (int i = 0; i < 8; i++) begin sym_valid = pat[i]; tick; end
    sym_valid = 1;
    run_to_idle(100, 0);
    chk("n5_ext", ext_cnt - e0, 5);
    chk("n5_wr", wr_cnt - w0, 5);
    chk("n5_last_wr", last_wr_addr, 4);
    chk("n5_trbk", trbk_cnt - t0, 5);
    chk("n5_done", done_cnt - d0, 1);

    r0 = err_cnt; d0 = done_cnt;
    frame(0, 100, 0);
    frame(1, 100, 0);
    frame(2, 100, 0);
    chk("err_pulses", err_cnt - r0, 2);
    chk("n2_done", done_cnt - d0, 1);

    e0 = ext_cnt; w0 = wr_cnt;
    start = 1; frame_len = 6; tick;
    for (int i = 0; i < 200 && ph != M_IDLE; i++) begin
      sym_valid = $urandom_range(99) < 70;
      start = $urandom_range(1) == 1;
      frame_len = 3;
      tick;
    end
    start = 0;
    chk("spam_ext", ext_cnt - e0, 6);
    chk("spam_wr", wr_cnt - w0, 6);
    chk("spam_last_wr", last_wr_addr, 5);

    t0 = trbk_cnt; d0 = done_cnt;
    start = 1; frame_len = 6; sym_valid = 1; tick; start = 0;
    for (k = 0; k < 100 && ph != M_TRBK; k++) tick;
    if (ph != M_TRBK) begin
      n_chk++; n_fail++;
      $display("FAIL trbk_timeout: phase %0d, required traceback", ph);
    end
    tick; tick;
    rst = 1; tick; rst = 0;
    tick; tick;
    chk("rst_trbk_cycles", trbk_cnt - t0, 3);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_busy", busy, 0);

    d0 = done_cnt;
    start = 1; frame_len = 3; sym_valid = 1;
    for (k = 0; k < 100 && done_cnt - d0 < 2; k++) tick;
    start = 0;
    run_to_idle(100, 0);
    chk("b2b_period", done_cyc - prev_done_cyc, 10);

    repeat (25) frame($urandom_range(0, 12), $urandom_range(30, 100), $urandom_range(0, 1) == 1);

    e0 = ext_cnt; w0 = wr_cnt; t0 = trbk_cnt; d0 = done_cnt;
    frame(255, 80, 1);
    chk("n255_ext", ext_cnt - e0, 255);
    chk("n255_last_wr", last_wr_addr, 254);
    chk("n255_trbk", trbk_cnt - t0, 255);
    chk("n255_done", done_cnt - d0, 1);

    start4 = 1; fl4 = 15; sv4 = 1; tick; start4 = 0;
    w4 = 0; t4 = 0; d4 = 0; x4 = 0; b4 = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (en_ext4) x4++;
      if (en_brch4 && en_acs4) b4++;
      if (en_mem4 && !en_trbk4) begin chk("w4_mem_addr", mem_addr4, w4); w4++; end
      if (en_trbk4) begin chk("w4_tb_addr", tb_addr4, 14 - t4); t4++; end
      if (done4) d4++;
      if (err4) chk("w4_err", err4, 0);
      tick;
    end
    chk("w4_ext", x4, 15);
    chk("w4_brch", b4, 15);
    chk("w4_writes", w4, 15);
    chk("w4_trbk", t4, 15);
    chk("w4_done", d4, 1);
    chk("w4_busy_end", busy4, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/viterbi_ctrl_seq.md
# viterbi_ctrl_seq

Parametrised control sequencer for the Viterbi decoder datapath. It sequences the extract, branch-metric, ACS, survivor-memory and traceback stages over a frame whose length is set at run time; the frame length is not hard-wired. It adds a start/busy/done handshake, tolerates gaps in the input symbol stream, and drives survivor-memory write and traceback read addresses. It sits between the frame-level host logic and the datapath stage enables.

## Interface
- CNT_W, 8: width of frame-length, symbol, memory-address and traceback-address counters; maximum frame length N = 2^CNT_W − 1.
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  frame start request; sampled only in IDLE.
- frame_len  in  CNT_W  trellis steps N in the frame; latched when start is accepted.
- sym_valid  in  1  input symbol available this cycle.
- en_ext  out  1  extract enable (symbol consumed this cycle).
- en_brch  out  1  branch-metric enable.
- en_acs  out  1  add-compare-select enable.
- en_mem  out  1  survivor-memory enable (write in RUN, read in TRBK).
- en_trbk  out  1  traceback enable.
- mem_addr  out  CNT_W  survivor-memory write index.
- tb_addr  out  CNT_W  traceback read index.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- err  out  1  one-cycle pulse when start carries an illegal frame_len.

## Operation
- States: IDLE, RUN, TRBK, DONE. The state register and all counters are updated only on clk rising edges.
- IDLE: all enables are 0.
  - start=1 with frame_len ≥ 2: latch N = frame_len, clear sym_cnt, mem_addr and pipeline valid bits v1/v2, then go to RUN.
  - start=1 with frame_len < 2: pulse err for one cycle and stay in IDLE.
- RUN: en_ext = sym_valid & (sym_cnt < N). This is the only combinational input-to-output path.
  - sym_cnt increments on every en_ext.
  - Every cycle: v1 <= en_ext and v2 <= v1.
  - en_brch = en_acs = v1; en_mem = v2. Each stage runs one cycle after the previous one.
  - A low sym_valid inserts a bubble that propagates down the pipeline. Stages are never held or stalled.
  - mem_addr increments after each en_mem cycle.
  - When en_mem=1 and mem_addr = N−1, go to TRBK and load tb_addr = N−1.
- TRBK: en_trbk = en_mem = 1; en_ext, en_brch and en_acs are 0.
  - tb_addr decrements each cycle.
  - After the cycle with tb_addr = 0, go to DONE. TRBK therefore lasts exactly N cycles.
- DONE: done = 1 and all enables are 0; the next state is IDLE.
- start outside IDLE is ignored; it does not set err and the latched N is unchanged.
- sym_valid outside RUN, and after sym_cnt = N, is ignored (en_ext stays 0).
- Counters never wrap: N ≤ 2^CNT_W − 1, and every compare uses the latched N.

## Timing
- Reset values: state IDLE; all enables, busy, done and err are 0; mem_addr = tb_addr = sym_cnt = 0; v1 = v2 = 0.
- rst asserted in any state: the next edge returns to IDLE with the reset values above. Any in-flight frame is abandoned and done is not pulsed.
- err is registered: it is high in cycle s+1 for a start sampled at edge s.
- Cycle numbering: start is sampled at edge s; RUN begins in cycle s+1; the first en_ext can occur in cycle s+1.
- Continuous sym_valid, first en_ext in cycle t:
  - en_ext high in cycles t .. t+N−1.
  - en_brch/en_acs high in t+1 .. t+N.
  - en_mem (write) high in t+2 .. t+N+1, with mem_addr 0 .. N−1.
  - TRBK in t+N+2 .. t+2N+1, with tb_addr N−1 .. 0.
  - done in t+2N+2; IDLE in t+2N+3.
- busy rises in cycle s+1 and falls in the cycle after DONE.
- A new start may be accepted in the first IDLE cycle after DONE, which gives back-to-back frames.

## Test plan
- Reset and idle: hold rst 3 cycles with start=1 and sym_valid=1 → all outputs 0, busy=0, no err.
- N=4, continuous sym_valid: en_ext for 4 cycles; en_mem writes mem_addr 0,1,2,3; TRBK 4 cycles with tb_addr 3,2,1,0; done exactly 2N+2 = 10 cycles after the first en_ext.
- N=5, sym_valid pattern 1,0,1,1,0,0,1,1:
  - exactly 5 en_ext pulses.
  - en_brch equals en_ext delayed by 1, and en_mem equals en_ext delayed by 2.
  - mem_addr is contiguous 0..4.
  - TRBK starts the cycle after the en_mem with mem_addr 4.
- frame_len=0 and frame_len=1 with start → err pulses one cycle, busy stays 0; then frame_len=2 → normal frame, done asserts.
- start asserted during RUN and TRBK with frame_len=3 → ignored. rst asserted mid-TRBK → IDLE next cycle, no done, mem_addr = tb_addr = 0.
- CNT_W=4, N=15, continuous → mem_addr reaches 15−1=14 with no wrap, tb_addr 14..0, done once.
